hssi_kpi_monitor: RTL and testbench



---
 rtl/hssi_kpi_pkg.sv | 28 ++
 rtl/hssi_kpi_ch_cnt.sv | 80 ++++++++
 rtl/hssi_kpi_monitor.sv | 157 +++++++++++++++
 tb/tb_hssi_kpi_monitor.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hssi_kpi_pkg.sv
// Shared types and constants for the HSSI KPI monitor.
package hssi_kpi_pkg;

  // Measurement window state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Readout field select.
  typedef enum logic [2:0] {
    SEL_BYTES  = 3'd0,
    SEL_PKTS   = 3'd1,
    SEL_ACTIVE = 3'd2,
    SEL_WIRE   = 3'd3,
    SEL_WINDOW = 3'd4,
    SEL_STATUS = 3'd5
  } rd_sel_t;

  // Ethernet per-packet wire overhead components, in bytes.
  localparam int OVH_PREAMBLE = 7;
  localparam int OVH_SFD      = 1;
  localparam int OVH_IPG      = 12;
  localparam int OVH_FCS      = 4;
  localparam int OVH_DEFAULT  = OVH_PREAMBLE + OVH_SFD + OVH_IPG + OVH_FCS;

endpackage

// File: rtl/hssi_kpi_ch_cnt.sv
// Per-channel KPI counters: payload bytes, packets, and first-beat to
// last-EOP active cycle count. All counters saturate.
module hssi_kpi_ch_cnt
  import hssi_kpi_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                run,
  input  logic                en,
  input  logic                tvalid,
  input  logic                tready,
  input  logic                tlast,
  input  logic [DATA_W/8-1:0] tkeep,
  output logic [CNT_W-1:0]    bytes,
  output logic [CNT_W-1:0]    pkts,
  output logic [CNT_W-1:0]    active_cycles,
  output logic                first_seen
);

  localparam int KW = DATA_W / 8;
  localparam int PW = $clog2(KW + 1);
  localparam int SW = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             beat;
  logic [PW-1:0]    keep_cnt;
  logic [SW-1:0]    bytes_sum;
  logic [CNT_W-1:0] bytes_nxt;
  logic [CNT_W-1:0] pkts_nxt;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_nxt;

  // A beat is an accepted transfer on an enabled channel while the window is open.
  assign beat = run & en & tvalid & tready;

  // Count set tkeep bits; tkeep may be non-contiguous.
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KW; i++) begin
      keep_cnt = keep_cnt + PW'(tkeep[i]);
    end
  end

  // Saturating next values for the byte, packet and running cycle counters.
  always_comb begin
    bytes_sum = {1'b0, bytes} + SW'(keep_cnt);
    bytes_nxt = bytes_sum[CNT_W] ? CNT_MAX : bytes_sum[CNT_W-1:0];
    pkts_nxt  = (pkts == CNT_MAX) ? CNT_MAX : pkts + CNT_W'(1);
    run_nxt   = (run_cnt == CNT_MAX) ? CNT_MAX : run_cnt + CNT_W'(1);
  end

  // Counter state; the running cycle count starts on the first-beat cycle
  // and active_cycles snapshots it (including the current cycle) on each EOP.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bytes         <= '0;
      pkts          <= '0;
      active_cycles <= '0;
      run_cnt       <= '0;
      first_seen    <= 1'b0;
    end else begin
      if (run && (first_seen || beat)) begin
        run_cnt <= run_nxt;
      end
      if (beat) begin
        first_seen <= 1'b1;
        bytes      <= bytes_nxt;
        if (tlast) begin
          pkts          <= pkts_nxt;
          active_cycles <= run_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/hssi_kpi_monitor.sv
// Passive multi-channel AXI-S KPI monitor with start/stop window,
// packet-target auto-completion and a registered readout port.
module hssi_kpi_monitor
  import hssi_kpi_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 64,
  parameter int CNT_W          = 48,
  parameter int OVERHEAD_BYTES = OVH_DEFAULT,
  parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [CNT_W-1:0]             pkt_target,
  input  logic [NUM_CH-1:0]            mon_tvalid,
  input  logic [NUM_CH-1:0]            mon_tready,
  input  logic [NUM_CH-1:0]            mon_tlast,
  input  logic [NUM_CH*DATA_W/8-1:0]   mon_tkeep,
  input  logic [CH_W-1:0]              rd_ch,
  input  logic [2:0]                   rd_sel,
  output logic [CNT_W-1:0]             rd_data,
  output logic                         busy,
  output logic                         done
);

  localparam int KW = DATA_W / 8;
  localparam int WW = CNT_W + 17;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [NUM_CH-1:0] en;
  logic              run;
  logic [CNT_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  bytes_a  [NUM_CH];
  logic [CNT_W-1:0]  pkts_a   [NUM_CH];
  logic [CNT_W-1:0]  active_a [NUM_CH];
  logic [NUM_CH-1:0] first_seen;
  logic              all_met;
  logic              auto_done;
  logic [CNT_W-1:0]  sel_bytes;
  logic [CNT_W-1:0]  sel_pkts;
  logic [CNT_W-1:0]  sel_active;
  logic              sel_first;
  logic              sel_en;
  logic [WW-1:0]     wire_wide;
  logic [CNT_W-1:0]  wire_sat;
  logic [CNT_W-1:0]  rd_next;

  assign run = (state == ST_RUN);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    hssi_kpi_ch_cnt #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_cnt (
      .clk           (clk),
      .rst           (rst),
      .clear         (start),
      .run           (run),
      .en            (en[c]),
      .tvalid        (mon_tvalid[c]),
      .tready        (mon_tready[c]),
      .tlast         (mon_tlast[c]),
      .tkeep         (mon_tkeep[c*KW +: KW]),
      .bytes         (bytes_a[c]),
      .pkts          (pkts_a[c]),
      .active_cycles (active_a[c]),
      .first_seen    (first_seen[c])
    );
  end

  // Auto-done once every enabled channel's registered packet count meets the target.
  always_comb begin
    all_met = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (en[c] && (pkts_a[c] < pkt_target)) begin
        all_met = 1'b0;
      end
    end
    auto_done = (pkt_target != '0) && (en != '0) && all_met;
  end

  // Window FSM with registered busy/done; start has priority over stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      en    <= '0;
    end else if (start) begin
      state <= ST_RUN;
      busy  <= 1'b1;
      done  <= 1'b0;
      en    <= ch_en;
    end else if ((state == ST_RUN) && (stop || auto_done)) begin
      state <= ST_DONE;
      busy  <= 1'b0;
      done  <= 1'b1;
    end
  end

  // Window length in cycles, saturating, cleared on start.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      win_cnt <= '0;
    end else if (run && (win_cnt != CNT_MAX)) begin
      win_cnt <= win_cnt + CNT_W'(1);
    end
  end

  // Channel mux; an out-of-range rd_ch leaves every field at zero.
  always_comb begin
    sel_bytes  = '0;
    sel_pkts   = '0;
    sel_active = '0;
    sel_first  = 1'b0;
    sel_en     = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) begin
        sel_bytes  = bytes_a[c];
        sel_pkts   = pkts_a[c];
        sel_active = active_a[c];
        sel_first  = first_seen[c];
        sel_en     = en[c];
      end
    end
  end

  // Field select, with wire bytes computed wide enough to never overflow before saturation.
  always_comb begin
    wire_wide = WW'(sel_bytes) + WW'(sel_pkts) * WW'(OVERHEAD_BYTES);
    wire_sat  = (wire_wide > WW'(CNT_MAX)) ? CNT_MAX : wire_wide[CNT_W-1:0];
    rd_next   = '0;
    case (rd_sel)
      SEL_BYTES:  rd_next = sel_bytes;
      SEL_PKTS:   rd_next = sel_pkts;
      SEL_ACTIVE: rd_next = sel_active;
      SEL_WIRE:   rd_next = wire_sat;
      SEL_WINDOW: rd_next = win_cnt;
      SEL_STATUS: rd_next = CNT_W'({sel_first, sel_en});
      default:    rd_next = '0;
    endcase
  end

  // Registered readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_hssi_kpi_monitor.sv
// Bench for hssi_kpi_monitor: a 48-bit and an 8-bit counter instance see the
// same traffic; readouts are checked against a cycle-level arithmetic model.
module tb_hssi_kpi_monitor;

  localparam int NUM_CH  = 4;
  localparam int KW      = 8;
  localparam int OVH     = 24;
  localparam int IDLE_ST = 0;
  localparam int RUN_ST  = 1;
  localparam int DONE_ST = 2;

  // clock / reset and DUT signals
  logic                 clk = 1'b0;
  logic                 rst, start, stop;
  logic [NUM_CH-1:0]    ch_en, mon_tvalid, mon_tready, mon_tlast;
  logic [47:0]          pkt_target;
  logic [NUM_CH*KW-1:0] mon_tkeep;
  logic [1:0]           rd_ch;
  logic [2:0]           rd_sel;
  logic [47:0]          rd_data;
  logic                 busy, done;
  logic [7:0]           rd_data8;
  logic                 busy8, done8;
  logic                 rd_issue = 1'b0;
  logic                 rd_vld = 1'b0;

  always #5 clk = ~clk;

  hssi_kpi_monitor dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .ch_en(ch_en),
    .pkt_target(pkt_target), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .mon_tlast(mon_tlast), .mon_tkeep(mon_tkeep), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .done(done)
  );

  hssi_kpi_monitor #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .ch_en(ch_en),
    .pkt_target(pkt_target[7:0]), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .mon_tlast(mon_tlast), .mon_tkeep(mon_tkeep), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data8), .busy(busy8), .done(done8)
  );

  // scoreboard state
  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];
  logic [4:0]  tag_q[$];
  logic [63:0] mon_exp;
  logic [4:0]  mon_tag;

  // reference model: unsaturated totals, saturation applied at compare time
  int                m_state;
  logic [NUM_CH-1:0] m_en;
  longint            m_bytes[NUM_CH];
  longint            m_pkts[NUM_CH];
  longint            m_active[NUM_CH];
  longint            m_first_cyc[NUM_CH];
  bit                m_first[NUM_CH];
  longint            m_win;
  longint            cyc;

  function automatic logic [63:0] sat(input logic [63:0] v, input int w);
    logic [63:0] mx;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_bytes[c] = 0; m_pkts[c] = 0; m_active[c] = 0; m_first_cyc[c] = 0; m_first[c] = 0;
    end
    m_win = 0;
  endtask

  // Apply the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit auto_ok;
    if (rst) begin
      m_state = IDLE_ST; m_en = '0; model_clear();
    end else if (start) begin
      m_state = RUN_ST; m_en = ch_en; model_clear();
    end else if (m_state == RUN_ST) begin
      auto_ok = (pkt_target != 48'd0) && (m_en != '0);
      for (int c = 0; c < NUM_CH; c++)
        if (m_en[c] && (m_pkts[c] < longint'(pkt_target))) auto_ok = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_en[c] && mon_tvalid[c] && mon_tready[c]) begin
          if (!m_first[c]) begin m_first[c] = 1; m_first_cyc[c] = cyc; end
          m_bytes[c] += $countones(mon_tkeep[c*KW +: KW]);
          if (mon_tlast[c]) begin
            m_pkts[c]++;
            m_active[c] = cyc - m_first_cyc[c] + 1;
          end
        end
      end
      m_win++;
      if (stop || auto_ok) m_state = DONE_ST;
    end
    cyc++;
  endtask

  function automatic logic [63:0] model_read(input logic [1:0] ch, input logic [2:0] sel);
    case (sel)
      3'd0: return 64'(m_bytes[ch]);
      3'd1: return 64'(m_pkts[ch]);
      3'd2: return 64'(m_active[ch]);
      3'd3: return 64'(m_bytes[ch] + m_pkts[ch] * OVH);
      3'd4: return 64'(m_win);
      3'd5: return {62'd0, m_first[ch], m_en[ch]};
      default: return 64'd0;
    endcase
  endfunction

  // driver tasks
  task automatic tick();
    if (rd_issue) begin
      exp_q.push_back(model_read(rd_ch, rd_sel));
      tag_q.push_back({rd_ch, rd_sel});
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; mon_tvalid = '0; mon_tready = '1; mon_tlast = '0; mon_tkeep = '0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"},  64'(busy),  64'(m_state == RUN_ST));
    check({tag, "_done"},  64'(done),  64'(m_state == DONE_ST));
    check({tag, "_busy8"}, 64'(busy8), 64'(m_state == RUN_ST));
    check({tag, "_done8"}, 64'(done8), 64'(m_state == DONE_ST));
  endtask

  task automatic read_all(input int ch);
    for (int s = 0; s < 8; s++) begin
      rd_ch = 2'(ch); rd_sel = 3'(s); rd_issue = 1; tick();
    end
    rd_issue = 0;
  endtask

  task automatic send_pkt(input int c, input int n, input bit rand_keep, input logic [7:0] last_keep);
    for (int b = 0; b < n; b++) begin
      mon_tvalid[c] = 1; mon_tready[c] = 1; mon_tlast[c] = (b == n - 1);
      if (rand_keep) mon_tkeep[c*KW +: KW] = 8'($urandom_range(0, 255));
      else           mon_tkeep[c*KW +: KW] = (b == n - 1) ? last_keep : 8'hFF;
      tick();
    end
    mon_tvalid[c] = 0; mon_tlast[c] = 0; mon_tkeep[c*KW +: KW] = 8'h00;
  endtask

  task automatic begin_run(input logic [3:0] en, input int target);
    idle_inputs(); ch_en = en; pkt_target = 48'(target); start = 1; tick(); start = 0;
  endtask

  // monitor: pops an expectation for every registered readout
  always @(posedge clk) rd_vld <= rd_issue;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_underflow: got a readout, expected a queued value");
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        tests++;
        if (64'(rd_data) !== sat(mon_exp, 48)) begin
          fails++;
          $display("FAIL rd48 ch%0d sel%0d: got %0d, expected %0d", mon_tag[4:3], mon_tag[2:0], rd_data, sat(mon_exp, 48));
        end
        tests++;
        if (64'(rd_data8) !== sat(mon_exp, 8)) begin
          fails++;
          $display("FAIL rd8 ch%0d sel%0d: got %0d, expected %0d", mon_tag[4:3], mon_tag[2:0], rd_data8, sat(mon_exp, 8));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    cyc = 0; m_state = IDLE_ST; m_en = '0; model_clear();
    idle_inputs(); ch_en = '0; pkt_target = '0; rd_ch = '0; rd_sel = '0;

    // reset state
    rst = 1; tick(); tick(); rst = 0;
    check_status("rst");
    check("rst_rd", 64'(rd_data), 64'd0);
    check("rst_rd8", 64'(rd_data8), 64'd0);
    read_all(0);

    // stop alone in IDLE is ignored
    stop = 1; tick(); stop = 0; tick();
    check_status("idle_stop");

    // 128 x 132-byte packets on ch0 with auto-done at 128
    begin_run(4'b0001, 128);
    for (int p = 0; p < 128; p++) send_pkt(0, 17, 0, 8'h0F);
    check_status("t1_last");
    for (int i = 0; i < 3; i++) begin tick(); check_status("t1_wait"); end
    check("t1_done", 64'(done), 64'd1);
    read_all(0);

    // four channels, target 10, ch2 lags by one packet
    begin_run(4'b1111, 10);
    for (int c = 0; c < NUM_CH; c++)
      for (int p = 0; p < ((c == 2) ? 9 : 10); p++) send_pkt(c, $urandom_range(1, 3), 1, 8'h00);
    for (int i = 0; i < 3; i++) begin tick(); check_status("t2_lag"); end
    check("t2_busy", 64'(busy), 64'd1);
    send_pkt(2, 2, 1, 8'h00);
    for (int i = 0; i < 3; i++) begin tick(); check_status("t2_wait"); end
    check("t2_done", 64'(done), 64'd1);
    send_pkt(0, 3, 1, 8'h00);
    for (int c = 0; c < NUM_CH; c++) read_all(c);

    // start and stop together while running restarts the window
    begin_run(4'b1111, 0);
    send_pkt(3, 4, 1, 8'h00);
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    check_status("ss");
    check("ss_busy", 64'(busy), 64'd1);
    read_all(3);

    // stall inside a packet, ch1 disabled but carrying traffic
    begin_run(4'b1101, 0);
    mon_tvalid[1] = 1; mon_tready[1] = 1; mon_tkeep[15:8] = 8'hFF;
    for (int b = 0; b < 7; b++) begin
      mon_tvalid[0] = 1;
      mon_tready[0] = !(b >= 2 && b <= 4);
      mon_tlast[0]  = (b == 6);
      mon_tlast[1]  = (b == 3) || (b == 6);
      mon_tkeep[7:0] = 8'($urandom_range(0, 255));
      tick();
    end
    idle_inputs(); stop = 1; tick(); stop = 0;
    check_status("stall");
    read_all(0); read_all(1);

    // reset mid-packet discards the run
    begin_run(4'b0001, 0);
    for (int b = 0; b < 5; b++) begin
      mon_tvalid[0] = 1; mon_tlast[0] = 0; mon_tkeep[7:0] = 8'hFF; tick();
    end
    idle_inputs(); rst = 1; tick(); rst = 0;
    check_status("mid_rst");
    check("mid_rst_rd", 64'(rd_data), 64'd0);
    read_all(0);
    begin_run(4'b0001, 0);
    send_pkt(0, 2, 1, 8'h00);
    stop = 1; tick(); stop = 0;
    read_all(0);

    // saturation: 40 full beats (320 bytes)
    begin_run(4'b0001, 0);
    send_pkt(0, 40, 0, 8'hFF);
    stop = 1; tick(); stop = 0;
    read_all(0);

    // randomized runs with interleaved reads
    for (int r = 0; r < 6; r++) begin
      begin_run(4'($urandom_range(0, 15)), $urandom_range(0, 4));
      for (int t = 0; t < 160; t++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          mon_tvalid[c] = 1'($urandom_range(0, 1));
          mon_tready[c] = ($urandom_range(0, 3) != 0);
          mon_tlast[c]  = ($urandom_range(0, 3) == 0);
          mon_tkeep[c*KW +: KW] = 8'($urandom_range(0, 255));
        end
        stop  = ($urandom_range(0, 99) == 0);
        start = ($urandom_range(0, 149) == 0);
        if (start) ch_en = 4'($urandom_range(0, 15));
        rd_issue = ($urandom_range(0, 2) == 0);
        rd_ch    = 2'($urandom_range(0, 3));
        rd_sel   = 3'($urandom_range(0, 7));
        tick();
        check_status("rnd");
      end
      rd_issue = 0; idle_inputs(); stop = 1; tick(); stop = 0;
      check_status("rnd_end");
      for (int c = 0; c < NUM_CH; c++) read_all(c);
    end

    idle_inputs(); tick(); tick(); tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
